// File: rtl/load_store_unit.sv
// Load/store stage between the ALU/register file and data memory: aligns stores
// into byte lanes, extends loads, and flags misaligned or illegal accesses.
module load_store_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  is_store,
  input  logic [2:0]            funct3,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] store_data,
  output logic                  busy,
  output logic                  done,
  output logic                  fault,
  output logic [DATA_WIDTH-1:0] load_data,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [3:0]            mem_wstrb,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ready,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t state, state_next;

  logic       fault_q;
  logic       we_q;
  logic [2:0] funct3_q;
  logic [1:0] lane_q;

  logic                  start_fault;
  logic [3:0]            start_wstrb;
  logic [DATA_WIDTH-1:0] start_wdata;
  logic [7:0]            rd_byte;
  logic [15:0]           rd_half;
  logic [DATA_WIDTH-1:0] load_ext;

  // funct3[1:0] gives the access size; funct3[2] is only legal as the unsigned flag on LBU/LHU
  always_comb begin
    start_fault = 1'b0;
    start_wstrb = 4'b0000;
    start_wdata = store_data;
    case (funct3[1:0])
      2'b00: begin
        start_wstrb = 4'b0001 << addr[1:0];
        start_wdata = {4{store_data[7:0]}};
      end
      2'b01: begin
        start_fault = addr[0];
        start_wstrb = 4'b0011 << addr[1:0];
        start_wdata = {2{store_data[15:0]}};
      end
      2'b10: begin
        start_fault = (addr[1:0] != 2'b00);
        start_wstrb = 4'b1111;
      end
      default: start_fault = 1'b1;
    endcase
    if (funct3[2] && (is_store || funct3[1]))
      start_fault = 1'b1;
    if (!is_store)
      start_wstrb = 4'b0000;
  end

  always_comb begin
    rd_byte  = mem_rdata[8*lane_q +: 8];
    rd_half  = mem_rdata[16*lane_q[1] +: 16];
    load_ext = mem_rdata;
    case (funct3_q)
      3'b000:  load_ext = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  load_ext = {{16{rd_half[15]}}, rd_half};
      3'b100:  load_ext = {24'd0, rd_byte};
      3'b101:  load_ext = {16'd0, rd_half};
      default: load_ext = mem_rdata;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = start_fault ? DONE : REQ;
      REQ:     if (mem_ready) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request fields are captured once at acceptance so they stay stable through memory wait states
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      fault_q   <= 1'b0;
      we_q      <= 1'b0;
      funct3_q  <= 3'b000;
      lane_q    <= 2'b00;
      mem_addr  <= '0;
      mem_wstrb <= 4'b0000;
      mem_wdata <= '0;
      load_data <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && start) begin
        fault_q   <= start_fault;
        we_q      <= is_store;
        funct3_q  <= funct3;
        lane_q    <= addr[1:0];
        mem_addr  <= {addr[ADDR_WIDTH-1:2], 2'b00};
        mem_wstrb <= start_wstrb;
        mem_wdata <= start_wdata;
      end
      if (state == REQ && mem_ready && !we_q)
        load_data <= load_ext;
    end
  end

  assign busy    = (state != IDLE);
  assign done    = (state == DONE);
  assign fault   = done && fault_q;
  assign mem_req = (state == REQ);
  assign mem_we  = mem_req && we_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: hand-computed loads, stores, faults,
// wait states, mid-operation reset and ignored start pulses.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        busy, done, fault;
  logic [31:0] load_data;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  load_store_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .is_store(is_store),
    .funct3(funct3), .addr(addr), .store_data(store_data),
    .busy(busy), .done(done), .fault(fault), .load_data(load_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Runs one op from the current IDLE negedge; waits = cycles mem_ready stays low in REQ
  task automatic applyStimulus(input string tag, input logic st, input logic [2:0] f3,
                               input logic [31:0] a, input logic [31:0] sd,
                               input logic [31:0] rd, input int waits,
                               input logic exp_fault, input logic [31:0] exp_addr,
                               input logic [3:0] exp_wstrb, input logic [31:0] exp_wdata,
                               input logic [31:0] exp_load);
    is_store = st; funct3 = f3; addr = a; store_data = sd; mem_rdata = rd;
    mem_ready = 1'b0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    if (exp_fault) begin
      checkOutput({tag, " fault done"}, {31'd0, done}, 32'd1);
      checkOutput({tag, " fault flag"}, {31'd0, fault}, 32'd1);
      checkOutput({tag, " fault no req"}, {31'd0, mem_req}, 32'd0);
      checkOutput({tag, " fault load_data"}, load_data, exp_load);
    end else begin
      for (int w = 0; w <= waits; w++) begin
        checkOutput({tag, " req"}, {31'd0, mem_req}, 32'd1);
        checkOutput({tag, " busy"}, {31'd0, busy}, 32'd1);
        checkOutput({tag, " no done in req"}, {31'd0, done}, 32'd0);
        checkOutput({tag, " mem_we"}, {31'd0, mem_we}, {31'd0, st});
        checkOutput({tag, " mem_addr"}, mem_addr, exp_addr);
        checkOutput({tag, " mem_wstrb"}, {28'd0, mem_wstrb}, {28'd0, exp_wstrb});
        if (st) checkOutput({tag, " mem_wdata"}, mem_wdata, exp_wdata);
        mem_ready = (w == waits);
        @(negedge clk);
      end
      mem_ready = 1'b0;
      checkOutput({tag, " done"}, {31'd0, done}, 32'd1);
      checkOutput({tag, " no fault"}, {31'd0, fault}, 32'd0);
      checkOutput({tag, " req dropped"}, {31'd0, mem_req}, 32'd0);
      checkOutput({tag, " load_data"}, load_data, exp_load);
    end
    @(negedge clk);
    checkOutput({tag, " idle busy"}, {31'd0, busy}, 32'd0);
    checkOutput({tag, " idle done"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; is_store = 1'b0; funct3 = 3'b000;
    addr = '0; store_data = '0; mem_ready = 1'b0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    checkOutput("rst busy", {31'd0, busy}, 32'd0);
    checkOutput("rst done", {31'd0, done}, 32'd0);
    checkOutput("rst fault", {31'd0, fault}, 32'd0);
    checkOutput("rst mem_req", {31'd0, mem_req}, 32'd0);
    checkOutput("rst mem_we", {31'd0, mem_we}, 32'd0);
    checkOutput("rst mem_addr", mem_addr, 32'd0);
    checkOutput("rst mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
    checkOutput("rst mem_wdata", mem_wdata, 32'd0);
    checkOutput("rst load_data", load_data, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    //              tag    st    f3      addr   store_data    rdata       w  flt addr   wstrb    wdata         load
    applyStimulus("LB",   1'b0, 3'b000, 32'h103, 32'h0,        32'h80FF1234, 0, 1'b0, 32'h100, 4'b0000, 32'h0,        32'hFFFFFF80);
    applyStimulus("LBU",  1'b0, 3'b100, 32'h103, 32'h0,        32'h80FF1234, 0, 1'b0, 32'h100, 4'b0000, 32'h0,        32'h00000080);
    applyStimulus("LHU",  1'b0, 3'b101, 32'h102, 32'h0,        32'h80FF1234, 0, 1'b0, 32'h100, 4'b0000, 32'h0,        32'h000080FF);
    applyStimulus("SH",   1'b1, 3'b001, 32'h202, 32'h1234ABCD, 32'hFFFFFFFF, 0, 1'b0, 32'h200, 4'b1100, 32'hABCDABCD, 32'h000080FF);
    applyStimulus("LWmis",1'b0, 3'b010, 32'h101, 32'h0,        32'h0,        0, 1'b1, 32'h0,   4'b0000, 32'h0,        32'h000080FF);
    applyStimulus("L011", 1'b0, 3'b011, 32'h100, 32'h0,        32'h0,        0, 1'b1, 32'h0,   4'b0000, 32'h0,        32'h000080FF);
    applyStimulus("SW",   1'b1, 3'b010, 32'h300, 32'hDEADBEEF, 32'h0,        3, 1'b0, 32'h300, 4'b1111, 32'hDEADBEEF, 32'h000080FF);
    applyStimulus("LH",   1'b0, 3'b001, 32'h102, 32'h0,        32'h80FF1234, 1, 1'b0, 32'h100, 4'b0000, 32'h0,        32'hFFFF80FF);
    applyStimulus("LHlo", 1'b0, 3'b001, 32'h100, 32'h0,        32'h80FF1234, 0, 1'b0, 32'h100, 4'b0000, 32'h0,        32'h00001234);
    applyStimulus("LW",   1'b0, 3'b010, 32'h104, 32'h0,        32'h13579BDF, 0, 1'b0, 32'h104, 4'b0000, 32'h0,        32'h13579BDF);
    applyStimulus("SB",   1'b1, 3'b000, 32'h101, 32'h000000A5, 32'h0,        0, 1'b0, 32'h100, 4'b0010, 32'hA5A5A5A5, 32'h13579BDF);
    applyStimulus("SHmis",1'b1, 3'b001, 32'h301, 32'h0,        32'h0,        0, 1'b1, 32'h0,   4'b0000, 32'h0,        32'h13579BDF);
    applyStimulus("S100", 1'b1, 3'b100, 32'h300, 32'h0,        32'h0,        0, 1'b1, 32'h0,   4'b0000, 32'h0,        32'h13579BDF);

    // Reset during the second REQ cycle aborts the op and a late mem_ready is ignored
    is_store = 1'b0; funct3 = 3'b010; addr = 32'h400; mem_rdata = 32'hCAFEF00D; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    checkOutput("abort req1", {31'd0, mem_req}, 32'd1);
    @(negedge clk);
    checkOutput("abort req2", {31'd0, mem_req}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("abort mem_req", {31'd0, mem_req}, 32'd0);
    checkOutput("abort busy", {31'd0, busy}, 32'd0);
    checkOutput("abort done", {31'd0, done}, 32'd0);
    checkOutput("abort mem_addr", mem_addr, 32'd0);
    checkOutput("abort wstrb", {28'd0, mem_wstrb}, 32'd0);
    checkOutput("abort wdata", mem_wdata, 32'd0);
    checkOutput("abort load_data", load_data, 32'd0);
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    checkOutput("late ready done", {31'd0, done}, 32'd0);
    checkOutput("late ready busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    checkOutput("late ready done2", {31'd0, done}, 32'd0);
    checkOutput("late ready load", load_data, 32'd0);

    // start held high through REQ and DONE with different fields must not disturb the op
    is_store = 1'b0; funct3 = 3'b010; addr = 32'h500; mem_rdata = 32'h11223344; start = 1'b1;
    @(negedge clk);
    is_store = 1'b1; addr = 32'h600; store_data = 32'h55555555;
    checkOutput("ign req1", {31'd0, mem_req}, 32'd1);
    @(negedge clk);
    checkOutput("ign addr", mem_addr, 32'h500);
    checkOutput("ign we", {31'd0, mem_we}, 32'd0);
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    checkOutput("ign done", {31'd0, done}, 32'd1);
    checkOutput("ign load", load_data, 32'h11223344);
    @(negedge clk);
    start = 1'b0;
    checkOutput("ign idle busy", {31'd0, busy}, 32'd0);
    checkOutput("ign idle req", {31'd0, mem_req}, 32'd0);
    applyStimulus("b2b LBU", 1'b0, 3'b100, 32'h701, 32'h0, 32'h0000AB00, 0, 1'b0, 32'h700, 4'b0000, 32'h0, 32'h000000AB);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
